// File: rtl/hv_bundle_cnt.sv
// Hypervector bundler: per-channel saturating counters over a beat stream,
// majority-thresholded result handed off through a valid/ready output.
module hv_bundle_cnt #(
    parameter int unsigned DW  = 8,
    parameter int unsigned NCH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           mode,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_last,
    input  logic [NCH-1:0] in_bits,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [NCH-1:0] out_hv,
    output logic [DW-1:0]  out_n,
    output logic           sat
);

    localparam logic [DW-1:0] UMAX = {DW{1'b1}};
    localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ACC = 2'd0,
        THR = 2'd1,
        OUT = 2'd2
    } state_t;

    state_t         state;
    logic [DW-1:0]  cnt_q   [NCH];
    logic [DW-1:0]  cnt_nxt [NCH];
    logic [DW-1:0]  n_q;
    logic [DW-1:0]  n_nxt;
    logic           mode_q;
    logic           eff_mode;
    logic           acc_sat;
    logic [NCH-1:0] thr_hv;

    // Next counter values for an accepted beat; mode is taken live on the first beat only.
    always_comb begin
        eff_mode = (n_q == '0) ? mode : mode_q;
        acc_sat  = 1'b0;
        for (int i = 0; i < int'(NCH); i++) begin
            cnt_nxt[i] = cnt_q[i];
            if (!eff_mode) begin
                if (in_bits[i]) begin
                    if (cnt_q[i] == UMAX) acc_sat = 1'b1;
                    else                  cnt_nxt[i] = cnt_q[i] + DW'(1);
                end
            end else if (in_bits[i]) begin
                if (cnt_q[i] == SMAX) acc_sat = 1'b1;
                else                  cnt_nxt[i] = cnt_q[i] + DW'(1);
            end else begin
                if (cnt_q[i] == SMIN) acc_sat = 1'b1;
                else                  cnt_nxt[i] = cnt_q[i] - DW'(1);
            end
        end
        n_nxt = n_q;
        if (n_q == UMAX) acc_sat = 1'b1;
        else             n_nxt = n_q + DW'(1);
    end

    // Majority threshold: unipolar uses 2*cnt > n at DW+1 bits, bipolar uses cnt > 0.
    always_comb begin
        thr_hv = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (mode_q) thr_hv[i] = !cnt_q[i][DW-1] && (cnt_q[i] != '0);
            else        thr_hv[i] = {cnt_q[i], 1'b0} > {1'b0, n_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            for (int i = 0; i < int'(NCH); i++) cnt_q[i] <= '0;
            n_q       <= '0;
            mode_q    <= 1'b0;
            sat       <= 1'b0;
            out_hv    <= '0;
            out_n     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (clr) begin
            state     <= ACC;
            for (int i = 0; i < int'(NCH); i++) cnt_q[i] <= '0;
            n_q       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ACC: begin
                    if (in_valid) begin
                        for (int i = 0; i < int'(NCH); i++) cnt_q[i] <= cnt_nxt[i];
                        n_q    <= n_nxt;
                        mode_q <= eff_mode;
                        if (acc_sat) sat <= 1'b1;
                        if (in_last) begin
                            state    <= THR;
                            in_ready <= 1'b0;
                        end
                    end
                end
                THR: begin
                    out_hv    <= thr_hv;
                    out_n     <= n_q;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    // Result consumed: start a fresh bundle, keep out_hv/out_n as last result.
                    if (out_ready) begin
                        for (int i = 0; i < int'(NCH); i++) cnt_q[i] <= '0;
                        n_q       <= '0;
                        sat       <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACC;
                    end
                end
                default: begin
                    state     <= ACC;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
